game_round_ctrl: RTL and testbench

//  Top-level sequencer for the memory-game core (game_module). Per round it: resets the core,

---
 rtl/game_round_ctrl.sv | 146 ++++++++++++++
 tb/tb_game_round_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/game_round_ctrl.sv
// Memory-game round sequencer: per round it clears the core, builds an 8-note LFSR pattern, loads and starts it.
// It then counts wins or detects inactivity. Strobes are registered, so each appears one cycle after the state decision.
module game_round_ctrl #(
    parameter int unsigned ROUNDS         = 3,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd12_000_000,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start_req,
    input  logic        abort_req,
    input  logic        keypad_strobe,
    input  logic        game_end,
    output logic        core_reset,
    output logic [31:0] pattern_out,
    output logic        write_enable,
    output logic        game_start,
    output logic [3:0]  round_count,
    output logic        busy,
    output logic        done,
    output logic        timeout
);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_GEN, S_LOAD, S_START, S_PLAY, S_FINISH, S_TIMEOUT
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [15:0] r_lfsr;
    logic        r_start_d, r_gend_d;
    logic [2:0]  r_gen_idx, w_gen_idx_nxt;
    logic [23:0] r_tmo_cnt, w_tmo_nxt;
    logic [31:0] r_pattern, w_pattern_nxt;
    logic [3:0]  r_round_cnt, w_round_nxt;
    logic        r_core_reset, r_write_en, r_game_start, r_busy, r_done, r_timeout;

    logic        w_start_edge, w_gend_edge, w_active, w_abort;
    logic [15:0] w_lfsr_1, w_lfsr_nxt;
    logic [4:0]  w_rc_plus1;
    logic [3:0]  w_rc_inc;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    assign w_lfsr_1     = lfsr_step(r_lfsr);
    assign w_lfsr_nxt   = keypad_strobe ? lfsr_step(w_lfsr_1) : w_lfsr_1;
    assign w_start_edge = start_req & ~r_start_d;
    assign w_gend_edge  = game_end & ~r_gend_d;
    assign w_active     = (r_state == S_CLEAR) || (r_state == S_GEN) || (r_state == S_LOAD) ||
                          (r_state == S_START) || (r_state == S_PLAY);
    assign w_abort      = abort_req & w_active;
    assign w_rc_plus1   = {1'b0, r_round_cnt} + 5'd1;
    assign w_rc_inc     = (r_round_cnt == 4'd15) ? 4'd15 : w_rc_plus1[3:0];

    always_comb begin
        w_state_nxt   = r_state;
        w_gen_idx_nxt = r_gen_idx;
        w_tmo_nxt     = r_tmo_cnt;
        w_pattern_nxt = r_pattern;
        w_round_nxt   = r_round_cnt;
        if (w_abort) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE, S_FINISH, S_TIMEOUT: begin
                    if (w_start_edge) begin
                        w_state_nxt = S_CLEAR;
                        w_round_nxt = 4'd0;
                    end
                end
                S_CLEAR: begin
                    w_gen_idx_nxt = 3'd0;
                    w_state_nxt   = S_GEN;
                end
                S_GEN: begin
                    w_pattern_nxt[{r_gen_idx, 2'b00} +: 4] = {1'b0, r_lfsr[2:0]} + 4'd1;
                    w_gen_idx_nxt = r_gen_idx + 3'd1;
                    if (r_gen_idx == 3'd7) w_state_nxt = S_LOAD;
                end
                S_LOAD:  w_state_nxt = S_START;
                S_START: begin
                    w_tmo_nxt   = 24'd0;
                    w_state_nxt = S_PLAY;
                end
                S_PLAY: begin
                    w_tmo_nxt = keypad_strobe ? 24'd0 : r_tmo_cnt + 24'd1;
                    // A win on the expiry cycle takes precedence over the timeout.
                    if (w_gend_edge) begin
                        w_round_nxt = w_rc_inc;
                        w_state_nxt = (w_rc_plus1 == 5'(ROUNDS)) ? S_FINISH : S_CLEAR;
                    end else if (!keypad_strobe && (r_tmo_cnt == TIMEOUT_CYCLES - 24'd1)) begin
                        w_state_nxt = S_TIMEOUT;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_lfsr       <= LFSR_SEED;
            r_start_d    <= 1'b0;
            r_gend_d     <= 1'b0;
            r_gen_idx    <= 3'd0;
            r_tmo_cnt    <= 24'd0;
            r_pattern    <= 32'd0;
            r_round_cnt  <= 4'd0;
            r_core_reset <= 1'b0;
            r_write_en   <= 1'b0;
            r_game_start <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_lfsr       <= w_lfsr_nxt;
            r_start_d    <= start_req;
            r_gend_d     <= game_end;
            r_gen_idx    <= w_gen_idx_nxt;
            r_tmo_cnt    <= w_tmo_nxt;
            r_pattern    <= w_pattern_nxt;
            r_round_cnt  <= w_round_nxt;
            // Abort lands in IDLE but still owes the core one reset pulse.
            r_core_reset <= (w_state_nxt == S_CLEAR) || w_abort;
            r_write_en   <= (w_state_nxt == S_LOAD);
            r_game_start <= (w_state_nxt == S_START);
            r_busy       <= (w_state_nxt != S_IDLE) && (w_state_nxt != S_FINISH) &&
                            (w_state_nxt != S_TIMEOUT);
            r_done       <= (w_state_nxt == S_FINISH);
            r_timeout    <= (w_state_nxt == S_TIMEOUT);
        end
    end

    assign core_reset   = r_core_reset;
    assign pattern_out  = r_pattern;
    assign write_enable = r_write_en;
    assign game_start   = r_game_start;
    assign round_count  = r_round_cnt;
    assign busy         = r_busy;
    assign done         = r_done;
    assign timeout      = r_timeout;

endmodule

// File: tb/tb_game_round_ctrl.sv
// Bench for game_round_ctrl: directed session flow with random delays and key stirring,
// with patterns predicted from an LFSR history model.
module tb_game_round_ctrl;
    localparam int          ROUNDS = 3;
    localparam logic [23:0] TMO    = 24'd20;
    localparam logic [15:0] SEED   = 16'hACE1;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0, start_req = 1'b0, abort_req = 1'b0;
    logic        keypad_strobe = 1'b0, game_end = 1'b0;
    logic        core_reset, write_enable, game_start, busy, done, timeout;
    logic [31:0] pattern_out;
    logic [3:0]  round_count;

    int n_pass = 0, n_total = 0, n_fail = 0;
    int cyc = 0;
    logic [15:0] m_lfsr = SEED;
    logic [15:0] hist [0:4095];
    logic [31:0] p1, p2, p3, px;

    always #5 clk = ~clk;

    game_round_ctrl #(.ROUNDS(ROUNDS), .TIMEOUT_CYCLES(TMO), .LFSR_SEED(SEED)) dut (
        .clk(clk), .reset_n(reset_n), .start_req(start_req), .abort_req(abort_req),
        .keypad_strobe(keypad_strobe), .game_end(game_end), .core_reset(core_reset),
        .pattern_out(pattern_out), .write_enable(write_enable), .game_start(game_start),
        .round_count(round_count), .busy(busy), .done(done), .timeout(timeout));

    function automatic logic [15:0] prbs_next(input logic [15:0] v);
        logic [15:0] s;
        s = v >> 1;
        if (v[0]) s = s ^ 16'hB400;
        return s;
    endfunction

    // Reference LFSR: hist[c] holds the register value during cycle c.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) m_lfsr = SEED;
        else begin
            hist[cyc % 4096] = m_lfsr;
            m_lfsr = prbs_next(m_lfsr);
            if (keypad_strobe) m_lfsr = prbs_next(m_lfsr);
        end
    end
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] exp_pat(input int r);
        logic [31:0] p;
        logic [15:0] v;
        p = 32'd0;
        for (int i = 0; i < 8; i++) begin
            v = hist[(r + 2 + i) % 4096];
            p[4*i +: 4] = 4'(v % 8) + 4'd1;
        end
        return p;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_core_reset"}, core_reset, 0);
        chk({tag, "_write_enable"}, write_enable, 0);
        chk({tag, "_game_start"}, game_start, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_timeout"}, timeout, 0);
        chk({tag, "_round_count"}, round_count, 0);
        chk({tag, "_pattern"}, pattern_out, 0);
    endtask

    // Called in the cycle whose clock edge sees the start / game_end edge.
    task automatic do_round(output logic [31:0] pat, input logic [3:0] exp_rc);
        int r, ok;
        r = cyc;
        pat = 32'd0;
        for (int k = 1; k <= 11; k++) begin
            tick();
            if (k == 1) begin
                start_req = 1'b0;
                game_end  = 1'b0;
            end
            keypad_strobe = (k <= 9) ? 1'($urandom_range(0, 1)) : 1'b0;
            chk("rnd_core_reset", core_reset, k == 1);
            chk("rnd_write_enable", write_enable, k == 10);
            chk("rnd_game_start", game_start, k == 11);
            chk("rnd_busy", busy, 1);
            if (k == 1) chk("rnd_round_count", round_count, exp_rc);
            if (k == 10) begin
                chk("rnd_pattern", pattern_out, exp_pat(r));
                ok = 0;
                for (int i = 0; i < 8; i++)
                    if (pattern_out[4*i +: 4] >= 4'd1 && pattern_out[4*i +: 4] <= 4'd8) ok++;
                chk("rnd_nibble_range", ok, 8);
                pat = pattern_out;
            end
            if (k == 11) chk("rnd_pattern_stable", pattern_out, pat);
        end
    endtask

    task automatic play_then_end(input int n, input logic [3:0] rc);
        for (int i = 0; i < n; i++) begin
            tick();
            chk("play_busy", busy, 1);
            chk("play_round_count", round_count, rc);
            chk("play_timeout", timeout, 0);
        end
        game_end = 1'b1;
    endtask

    initial begin
        // Reset state
        repeat (3) tick();
        chk_all_zero("reset");
        reset_n = 1'b1;
        repeat ($urandom_range(2, 6)) begin
            tick();
            keypad_strobe = 1'($urandom_range(0, 1));
            chk("idle_busy", busy, 0);
            chk("idle_core_reset", core_reset, 0);
        end

        // Three winning rounds
        tick();
        start_req = 1'b1;
        do_round(p1, 4'd0);
        play_then_end($urandom_range(1, 18), 4'd0);
        do_round(p2, 4'd1);
        chk("pat_diff_12", p2 != p1, 1);
        tick();
        start_req = 1'b1;
        tick();
        chk("busy_start_ignored", core_reset, 0);
        chk("busy_start_busy", busy, 1);
        play_then_end($urandom_range(1, 10), 4'd1);
        do_round(p3, 4'd2);
        chk("pat_diff_23", p3 != p2, 1);
        play_then_end($urandom_range(1, 18), 4'd2);
        tick();
        game_end = 1'b0;
        chk("fin_done", done, 1);
        chk("fin_busy", busy, 0);
        chk("fin_round_count", round_count, 3);
        chk("fin_core_reset", core_reset, 0);
        tick();
        game_end = 1'b1;
        tick();
        game_end = 1'b0;
        tick();
        chk("fin_gend_ignored_rc", round_count, 3);
        chk("fin_gend_ignored_done", done, 1);

        // Timeout deferred by a key on the last counted cycle
        start_req = 1'b1;
        do_round(px, 4'd0);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("tmo_defer_early", timeout, 0);
            if (i == 19) keypad_strobe = 1'b1;
        end
        tick();
        keypad_strobe = 1'b0;
        chk("tmo_deferred", timeout, 0);
        chk("tmo_deferred_busy", busy, 1);
        for (int i = 21; i < 40; i++) begin
            tick();
            chk("tmo_defer_wait", timeout, 0);
        end
        tick();
        chk("tmo_defer_expired", timeout, 1);
        chk("tmo_defer_busy", busy, 0);
        chk("tmo_defer_done", done, 0);

        // Plain timeout, exactly 20 cycles into PLAY
        tick();
        start_req = 1'b1;
        do_round(px, 4'd0);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("tmo_wait", timeout, 0);
        end
        tick();
        chk("tmo_expired", timeout, 1);
        chk("tmo_busy", busy, 0);
        chk("tmo_round_count", round_count, 0);

        // game_end on the expiry cycle wins, then abort during GEN
        start_req = 1'b1;
        do_round(px, 4'd0);
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i == 19) game_end = 1'b1;
        end
        tick();
        game_end = 1'b0;
        chk("race_timeout", timeout, 0);
        chk("race_round_count", round_count, 1);
        chk("race_core_reset", core_reset, 1);
        chk("race_busy", busy, 1);
        tick();
        tick();
        abort_req = 1'b1;
        tick();
        abort_req = 1'b0;
        chk("abort_core_reset", core_reset, 1);
        chk("abort_busy", busy, 0);
        chk("abort_round_count", round_count, 1);
        tick();
        chk("abort_core_reset_once", core_reset, 0);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("abort_no_write", write_enable, 0);
            chk("abort_no_start", game_start, 0);
            chk("abort_idle", busy, 0);
        end

        // Asynchronous reset in the middle of GEN
        start_req = 1'b1;
        repeat (5) tick();
        start_req = 1'b0;
        chk("gen_pattern_nonzero", pattern_out != 0, 1);
        reset_n = 1'b0;
        #1;
        chk_all_zero("async_reset");
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        tick();
        start_req = 1'b1;
        do_round(px, 4'd0);
        play_then_end($urandom_range(1, 18), 4'd0);
        tick();
        game_end = 1'b0;
        chk("post_reset_round_count", round_count, 1);
        chk("post_reset_core_reset", core_reset, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
